// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, text-segment bounds, FSM encoding.
// The controller and the instruction memory import this package too.
package pc_fetch_unit_pkg;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] TEXT_END = 32'h0000_6FFC;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } fetchState_t;

    // Word aligned and inside [lo, hi], unsigned.
    function automatic logic isLegal(input logic [31:0] addr, input logic [31:0] lo,
                                     input logic [31:0] hi);
        return (addr[1:0] == 2'b00) && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_npc_calc.sv
// Combinational next-PC selection plus the legality check on the chosen target.
module npc_calc
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] LO_PC = 32'h0000_3000,
    parameter logic [31:0] HI_PC = 32'h0000_6FFC
) (
    input  logic [31:0] pc,
    input  logic [1:0]  npcSel,
    input  logic        branchTaken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] regTarget,
    output logic [31:0] target,
    output logic        legal
);

    logic [31:0] seqPc;
    logic [31:0] brOff;

    assign seqPc = pc + 32'd4;
    assign brOff = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target = seqPc;
        case (npcSel)
            NPC_SEQ: target = seqPc;
            NPC_BR:  target = branchTaken ? seqPc + brOff : seqPc;
            NPC_J:   target = {pc[31:28], imm26, 2'b00};
            NPC_JR:  target = regTarget;
            default: target = seqPc;
        endcase
    end

    assign legal = isLegal(target, LO_PC, HI_PC);

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and fetch FSM; an illegal target latches a sticky fault
// that only reset clears.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = pc_fetch_unit_pkg::RESET_PC,
    parameter logic [31:0] TEXT_END = pc_fetch_unit_pkg::TEXT_END
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npcSel,
    input  logic        branchTaken,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] regTarget,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [11:0] instrAddr,
    output logic        fault,
    output logic [31:0] faultPC,
    output logic [31:0] fetchCount
);
    import pc_fetch_unit_pkg::fetchState_t;
    import pc_fetch_unit_pkg::S_RUN;
    import pc_fetch_unit_pkg::S_FAULT;

    fetchState_t state;
    logic [31:0] target;
    logic        legal;

    npc_calc #(
        .LO_PC(RESET_PC),
        .HI_PC(TEXT_END)
    ) uNpc (
        .pc         (pc),
        .npcSel     (npcSel),
        .branchTaken(branchTaken),
        .imm16      (imm16),
        .imm26      (imm26),
        .regTarget  (regTarget),
        .target     (target),
        .legal      (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_RUN;
            pc         <= RESET_PC;
            faultPC    <= 32'd0;
            fetchCount <= 32'd0;
        end else begin
            case (state)
                S_RUN: begin
                    // A stalled cycle never looks at the target, so it cannot fault.
                    if (!stall) begin
                        if (legal) begin
                            pc         <= target;
                            fetchCount <= fetchCount + 32'd1;
                        end else begin
                            state   <= S_FAULT;
                            faultPC <= target;
                        end
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_FAULT;
            endcase
        end
    end

    assign fault     = (state == S_FAULT);
    assign pc4       = pc + 32'd4;
    assign instrAddr = pc[13:2];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a plain-arithmetic reference model checked every
// cycle, plus literal expectations at the interesting points of the sequence.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  npcSel = 2'b00;
    logic        branchTaken = 1'b0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] imm26 = 26'd0;
    logic [31:0] regTarget = 32'd0;
    logic [31:0] pc, pc4, faultPC, fetchCount;
    logic [11:0] instrAddr;
    logic        fault;

    int passCnt = 0;
    int totalCnt = 0;

    pc_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .npcSel(npcSel),
        .branchTaken(branchTaken), .imm16(imm16), .imm26(imm26), .regTarget(regTarget),
        .pc(pc), .pc4(pc4), .instrAddr(instrAddr), .fault(fault),
        .faultPC(faultPC), .fetchCount(fetchCount)
    );

    always #5 clk = ~clk;

    // Reference model: architectural state only, next value from the stated rules.
    logic [31:0] mPc, mFaultPC, mCount, mT;
    logic        mFault, mLegal;

    function automatic logic [31:0] refTarget(input logic [31:0] p, input logic [1:0] s,
                                              input logic bt, input logic [15:0] i16,
                                              input logic [25:0] i26, input logic [31:0] rt);
        logic signed [31:0] off;
        off = 32'(signed'(i16)) * 4;
        if (s == 2'b00) return p + 4;
        if (s == 2'b01) return bt ? p + 4 + off : p + 4;
        if (s == 2'b10) return (p & 32'hF000_0000) | (32'(i26) * 4);
        return rt;
    endfunction

    always_comb begin
        mT     = refTarget(mPc, npcSel, branchTaken, imm16, imm26, regTarget);
        mLegal = (mT % 4 == 0) && (mT >= 32'h3000) && (mT <= 32'h6FFC);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPc <= 32'h3000; mFault <= 1'b0; mFaultPC <= 32'd0; mCount <= 32'd0;
        end else if (!mFault && !stall) begin
            if (mLegal) begin
                mPc <= mT; mCount <= mCount + 1;
            end else begin
                mFault <= 1'b1; mFaultPC <= mT;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model.pc", pc, mPc);
            chk("model.pc4", pc4, mPc + 4);
            chk("model.instrAddr", 32'(instrAddr), (mPc / 4) % 4096);
            chk("model.fault", 32'(fault), 32'(mFault));
            chk("model.faultPC", faultPC, mFaultPC);
            chk("model.fetchCount", fetchCount, mCount);
        end
    end

    // Apply one set of inputs starting at a falling edge; return after the next falling edge.
    task automatic step(input logic st, input logic [1:0] sel, input logic bt,
                        input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rt);
        stall = st; npcSel = sel; branchTaken = bt; imm16 = i16; imm26 = i26; regTarget = rt;
        @(negedge clk);
    endtask

    task automatic jr(input logic [31:0] rt);
        step(1'b0, NPC_JR, 1'b0, 16'd0, 26'd0, rt);
    endtask

    // Reset pulse placed strictly between clock edges; checks the asynchronous effect.
    task automatic midReset();
        stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async.pc", pc, 32'h3000);
        chk("async.fault", 32'(fault), 32'd0);
        chk("async.count", fetchCount, 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst.pc", pc, 32'h3000);
        chk("rst.pc4", pc4, 32'h3004);
        chk("rst.instrAddr", 32'(instrAddr), 32'hC00);
        chk("rst.fault", 32'(fault), 32'd0);
        chk("rst.faultPC", faultPC, 32'd0);
        chk("rst.count", fetchCount, 32'd0);

        step(1'b0, NPC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0);
        chk("seq1.pc", pc, 32'h3004); chk("seq1.ia", 32'(instrAddr), 32'hC01);
        step(1'b0, NPC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0);
        chk("seq2.pc", pc, 32'h3008); chk("seq2.ia", 32'(instrAddr), 32'hC02);
        step(1'b0, NPC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0);
        chk("seq3.pc", pc, 32'h300C); chk("seq3.ia", 32'(instrAddr), 32'hC03);
        chk("seq3.count", fetchCount, 32'd3);

        jr(32'h3008);
        step(1'b0, NPC_BR, 1'b1, 16'hFFFE, 26'd0, 32'd0);
        chk("brTaken.pc", pc, 32'h3004);
        jr(32'h3008);
        step(1'b0, NPC_BR, 1'b0, 16'hFFFE, 26'd0, 32'd0);
        chk("brNot.pc", pc, 32'h300C);

        step(1'b0, NPC_BR, 1'b1, 16'hFFFF, 26'd0, 32'd0);
        step(1'b0, NPC_BR, 1'b1, 16'hFFFF, 26'd0, 32'd0);
        chk("selfLoop.pc", pc, 32'h300C);
        chk("selfLoop.count", fetchCount, 32'd9);

        jr(32'h3000);
        step(1'b0, NPC_J, 1'b0, 16'd0, 26'h0000C10, 32'd0);
        chk("jump.pc", pc, 32'h3040);
        jr(32'h3000);
        jr(32'h3003);
        chk("misalign.fault", 32'(fault), 32'd1);
        chk("misalign.faultPC", faultPC, 32'h3003);
        chk("misalign.pc", pc, 32'h3000);
        chk("misalign.count", fetchCount, 32'd12);

        midReset();
        repeat (5) step(1'b1, NPC_JR, 1'b0, 16'd0, 26'd0, 32'd0);
        chk("stall.pc", pc, 32'h3000);
        chk("stall.count", fetchCount, 32'd0);
        chk("stall.fault", 32'(fault), 32'd0);
        jr(32'd0);
        chk("unstall.fault", 32'(fault), 32'd1);
        chk("unstall.faultPC", faultPC, 32'd0);

        for (int i = 0; i < 4; i++)
            step(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), 26'($urandom),
                 32'h3000 + 32'(4 * i));
        chk("frozen.pc", pc, 32'h3000);
        chk("frozen.fault", 32'(fault), 32'd1);
        chk("frozen.faultPC", faultPC, 32'd0);
        chk("frozen.count", fetchCount, 32'd0);
        midReset();

        jr(32'h6FFC);
        chk("textEnd.pc", pc, 32'h6FFC);
        chk("textEnd.fault", 32'(fault), 32'd0);
        step(1'b0, NPC_SEQ, 1'b0, 16'd0, 26'd0, 32'd0);
        chk("pastEnd.fault", 32'(fault), 32'd1);
        chk("pastEnd.faultPC", faultPC, 32'h7000);
        chk("pastEnd.pc", pc, 32'h6FFC);

        midReset();
        jr(32'h7000);
        chk("jrOver.faultPC", faultPC, 32'h7000);
        midReset();
        jr(32'h2FFC);
        chk("jrUnder.fault", 32'(fault), 32'd1);
        chk("jrUnder.faultPC", faultPC, 32'h2FFC);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
